dmem_ctrl: RTL and testbench

- Sequences data-SRAM accesses for the load/store pipe.
- Accepts one memory op per cycle from the EX stage and drives an SRAM-like split handshake: req/addr_ok for the address phase, data_ok for the data phase.
- Generates size, byte strobes and aligned write data for all MIPS load/store forms, including the unaligned ones.
- Returns raw read data plus addr[1:0] to the MEM stage, which does the load extraction; raises a stall request while an access is pending.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_req_encode.sv | 41 ++++
 rtl/dmem_ctrl.sv | 118 +++++++++++
 tb/tb_dmem_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: memop bit indices, data_size codes and FSM states shared by the data-memory controller
package dmem_pkg;
    localparam int MOP_LB  = 0;
    localparam int MOP_LBU = 1;
    localparam int MOP_LH  = 2;
    localparam int MOP_LHU = 3;
    localparam int MOP_LW  = 4;
    localparam int MOP_SB  = 5;
    localparam int MOP_SH  = 6;
    localparam int MOP_SW  = 7;
    localparam int MOP_LWL = 8;
    localparam int MOP_LWR = 9;
    localparam int MOP_SWL = 10;
    localparam int MOP_SWR = 11;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_HOLD, ST_DISCARD} state_e;
endpackage

// File: rtl/dmem_req_encode.sv
// dmem_req_encode: memop + address + rt to SRAM size, byte strobes, positioned write data and address
module dmem_req_encode
    import dmem_pkg::*;
#(
    parameter int MOP_W = 12,
    parameter int AW    = 32
) (
    input  logic [MOP_W-1:0] memop_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [31:0]      rt_i,
    output logic             wr_o,
    output logic [1:0]       size_o,
    output logic [AW-1:0]    addr_o,
    output logic [3:0]       wstrb_o,
    output logic [31:0]      wdata_o
);
    logic       byte_op, half_op, unal_op, swl, swr;
    logic [1:0] a;
    logic [3:0] strb;
    always_comb begin
        a       = addr_i[1:0];
        byte_op = memop_i[MOP_LB] | memop_i[MOP_LBU] | memop_i[MOP_SB];
        half_op = memop_i[MOP_LH] | memop_i[MOP_LHU] | memop_i[MOP_SH];
        unal_op = |memop_i[MOP_SWR:MOP_LWL];
        swl     = memop_i[MOP_SWL];
        swr     = memop_i[MOP_SWR];
        wr_o    = memop_i[MOP_SB] | memop_i[MOP_SH] | memop_i[MOP_SW] | swl | swr;
        size_o  = byte_op ? SZ_B : half_op ? SZ_H : SZ_W;
        addr_o  = unal_op ? {addr_i[AW-1:2], 2'b00} : addr_i;
        // swl fills from the low byte up to a; swr from a up to the top byte
        strb    = byte_op ? 4'b0001 << a :
                  half_op ? (a[1] ? 4'b1100 : 4'b0011) :
                  swl     ? 4'b1111 >> ~a :
                  swr     ? 4'b1111 << a : 4'b1111;
        wstrb_o = wr_o ? strb : 4'b0000;
        wdata_o = byte_op ? {4{rt_i[7:0]}} :
                  half_op ? {2{rt_i[15:0]}} :
                  swl     ? rt_i >> {~a, 3'b000} :
                  swr     ? rt_i << {a, 3'b000} : rt_i;
    end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: sequences one outstanding data-SRAM access per memop and returns raw read data to MEM
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int MOP_W = 12,
    parameter int AW    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid_i,
    input  logic [MOP_W-1:0] ex_memop_i,
    input  logic [AW-1:0]    ex_addr_i,
    input  logic [31:0]      ex_wdata_i,
    input  logic             pipe_stall_i,
    input  logic             flush_i,
    output logic             data_req,
    output logic             data_wr,
    output logic [1:0]       data_size,
    output logic [AW-1:0]    data_addr,
    output logic [3:0]       data_wstrb,
    output logic [31:0]      data_wdata,
    input  logic             data_addr_ok,
    input  logic [31:0]      data_rdata,
    input  logic             data_data_ok,
    output logic [31:0]      mem_rdata_o,
    output logic [1:0]       mem_addr_low_o,
    output logic             mem_rvalid_o,
    output logic             stallreq_o
);
    state_e        state_q, state_d;
    logic          wr_q, wr_d, enc_wr, rvalid_q, rvalid_d, accept, in_req;
    logic [1:0]    size_q, size_d, enc_size, alow_q, alow_d, rlow_q, rlow_d;
    logic [AW-1:0] addr_q, addr_d, enc_addr;
    logic [3:0]    wstrb_q, wstrb_d, enc_wstrb;
    logic [31:0]   wdata_q, wdata_d, enc_wdata, rdata_q, rdata_d;

    dmem_req_encode #(.MOP_W(MOP_W), .AW(AW)) u_enc (
        .memop_i (ex_memop_i),
        .addr_i  (ex_addr_i),
        .rt_i    (ex_wdata_i),
        .wr_o    (enc_wr),
        .size_o  (enc_size),
        .addr_o  (enc_addr),
        .wstrb_o (enc_wstrb),
        .wdata_o (enc_wdata)
    );

    always_comb begin
        // reset gates acceptance so the request drops the instant reset rises
        accept     = state_q == ST_IDLE && ex_valid_i && |ex_memop_i && !flush_i && !rst_n;
        in_req     = state_q == ST_REQ;
        data_req   = accept | in_req;
        data_wr    = !data_req ? 1'b0 : in_req ? wr_q : enc_wr;
        data_size  = !data_req ? 2'b00 : in_req ? size_q : enc_size;
        data_addr  = !data_req ? '0 : in_req ? addr_q : enc_addr;
        data_wstrb = !data_req ? 4'b0000 : in_req ? wstrb_q : enc_wstrb;
        data_wdata = !data_req ? 32'h0 : in_req ? wdata_q : enc_wdata;
        wr_d       = accept ? enc_wr : wr_q;
        size_d     = accept ? enc_size : size_q;
        addr_d     = accept ? enc_addr : addr_q;
        wstrb_d    = accept ? enc_wstrb : wstrb_q;
        wdata_d    = accept ? enc_wdata : wdata_q;
        alow_d     = accept ? ex_addr_i[1:0] : alow_q;
        stallreq_o = accept | in_req | state_q == ST_WAIT | state_q == ST_DISCARD;
        state_d    = state_q;
        rvalid_d   = 1'b0;
        rdata_d    = rdata_q;
        rlow_d     = rlow_q;
        case (state_q)
            ST_IDLE:    state_d = !accept ? ST_IDLE : data_addr_ok ? ST_WAIT : ST_REQ;
            ST_REQ:     state_d = flush_i ? (data_addr_ok ? ST_DISCARD : ST_IDLE) :
                                  (data_addr_ok ? ST_WAIT : ST_REQ);
            ST_WAIT: begin
                rvalid_d = data_data_ok && !flush_i;
                rdata_d  = rvalid_d ? data_rdata : rdata_q;
                rlow_d   = rvalid_d ? alow_q : rlow_q;
                state_d  = data_data_ok ? (rvalid_d && pipe_stall_i ? ST_HOLD : ST_IDLE) :
                           flush_i ? ST_DISCARD : ST_WAIT;
            end
            ST_HOLD: begin
                rvalid_d = pipe_stall_i && !flush_i;
                state_d  = rvalid_d ? ST_HOLD : ST_IDLE;
            end
            ST_DISCARD: state_d = data_data_ok ? ST_IDLE : ST_DISCARD;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= ST_IDLE;
            wr_q     <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wstrb_q  <= 4'b0000;
            wdata_q  <= 32'h0;
            alow_q   <= 2'b00;
            rdata_q  <= 32'h0;
            rlow_q   <= 2'b00;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            alow_q   <= alow_d;
            rdata_q  <= rdata_d;
            rlow_q   <= rlow_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign mem_rdata_o    = rdata_q;
    assign mem_addr_low_o = rlow_q;
    assign mem_rvalid_o   = rvalid_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed table and corner-case sequences for dmem_ctrl
module tb_dmem_ctrl;
    localparam logic [11:0] LB = 12'h001, LBU = 12'h002, LHU = 12'h008, LW = 12'h010;
    localparam logic [11:0] SB = 12'h020, SH = 12'h040, SW = 12'h080, LWL = 12'h100;
    localparam logic [11:0] SWL = 12'h400, SWR = 12'h800;

    logic        clk = 0, rst_n = 1;
    logic        ex_valid_i = 0, pipe_stall_i = 0, flush_i = 0;
    logic [11:0] ex_memop_i = 0;
    logic [31:0] ex_addr_i = 0, ex_wdata_i = 0, data_rdata = 0;
    logic        data_addr_ok = 0, data_data_ok = 0;
    logic        data_req, data_wr, mem_rvalid_o, stallreq_o;
    logic [1:0]  data_size, mem_addr_low_o;
    logic [31:0] data_addr, data_wdata, mem_rdata_o;
    logic [3:0]  data_wstrb;
    int          total = 0, bad = 0;

    dmem_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid_i), .ex_memop_i(ex_memop_i),
        .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i), .pipe_stall_i(pipe_stall_i),
        .flush_i(flush_i), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_rdata(data_rdata), .data_data_ok(data_data_ok),
        .mem_rdata_o(mem_rdata_o), .mem_addr_low_o(mem_addr_low_o),
        .mem_rvalid_o(mem_rvalid_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] op;
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] aaddr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [11:0] op, input logic [31:0] a, input logic [31:0] rt, input logic ack);
        ex_valid_i   = 1;
        ex_memop_i   = op;
        ex_addr_i    = a;
        ex_wdata_i   = rt;
        data_addr_ok = ack;
    endtask

    initial begin
        vecs[0]  = '{SB,  32'h200, 1, 2'd0, 32'h200, 4'b0001, 32'h44444444};
        vecs[1]  = '{SB,  32'h203, 1, 2'd0, 32'h203, 4'b1000, 32'h44444444};
        vecs[2]  = '{SB,  32'h201, 1, 2'd0, 32'h201, 4'b0010, 32'h44444444};
        vecs[3]  = '{SH,  32'h200, 1, 2'd1, 32'h200, 4'b0011, 32'h33443344};
        vecs[4]  = '{SH,  32'h202, 1, 2'd1, 32'h202, 4'b1100, 32'h33443344};
        vecs[5]  = '{SWL, 32'h200, 1, 2'd2, 32'h200, 4'b0001, 32'h00000011};
        vecs[6]  = '{SWL, 32'h201, 1, 2'd2, 32'h200, 4'b0011, 32'h00001122};
        vecs[7]  = '{SWL, 32'h202, 1, 2'd2, 32'h200, 4'b0111, 32'h00112233};
        vecs[8]  = '{SWL, 32'h203, 1, 2'd2, 32'h200, 4'b1111, 32'h11223344};
        vecs[9]  = '{SWR, 32'h200, 1, 2'd2, 32'h200, 4'b1111, 32'h11223344};
        vecs[10] = '{SWR, 32'h201, 1, 2'd2, 32'h200, 4'b1110, 32'h22334400};
        vecs[11] = '{SWR, 32'h202, 1, 2'd2, 32'h200, 4'b1100, 32'h33440000};
        vecs[12] = '{SWR, 32'h203, 1, 2'd2, 32'h200, 4'b1000, 32'h44000000};
        vecs[13] = '{LWL, 32'h207, 0, 2'd2, 32'h204, 4'b0000, 32'h0};
        vecs[14] = '{LBU, 32'h205, 0, 2'd0, 32'h205, 4'b0000, 32'h0};
        vecs[15] = '{LHU, 32'h206, 0, 2'd1, 32'h206, 4'b0000, 32'h0};

        #1;
        chk("rst_req", data_req, 0);
        chk("rst_rvalid", mem_rvalid_o, 0);
        chk("rst_stall", stallreq_o, 0);
        chk("rst_rdata", mem_rdata_o, 0);
        cyc(); cyc();
        rst_n = 0;

        // sw with immediate addr_ok, data_ok one cycle later
        cyc();
        issue(SW, 32'h100, 32'hDEADBEEF, 1);
        #1;
        chk("sw_req", data_req, 1);
        chk("sw_wr", data_wr, 1);
        chk("sw_size", data_size, 2);
        chk("sw_wstrb", data_wstrb, 4'b1111);
        chk("sw_wdata", data_wdata, 32'hDEADBEEF);
        chk("sw_addr", data_addr, 32'h100);
        chk("sw_stall0", stallreq_o, 1);
        cyc();
        ex_valid_i = 0; data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h0BADF00D;
        #1;
        chk("sw_req1", data_req, 0);
        chk("sw_stall1", stallreq_o, 1);
        chk("sw_rvalid1", mem_rvalid_o, 0);
        cyc();
        data_data_ok = 0;
        #1;
        chk("sw_rvalid2", mem_rvalid_o, 1);
        chk("sw_stall2", stallreq_o, 0);
        cyc();
        #1;
        chk("sw_rvalid3", mem_rvalid_o, 0);

        // encoding table
        for (int i = 0; i < 16; i++) begin
            cyc();
            issue(vecs[i].op, vecs[i].addr, 32'h11223344, 1);
            #1;
            chk($sformatf("v%0d_req", i), data_req, 1);
            chk($sformatf("v%0d_wr", i), data_wr, vecs[i].wr);
            chk($sformatf("v%0d_size", i), data_size, vecs[i].size);
            chk($sformatf("v%0d_addr", i), data_addr, vecs[i].aaddr);
            chk($sformatf("v%0d_wstrb", i), data_wstrb, vecs[i].wstrb);
            if (vecs[i].wr) chk($sformatf("v%0d_wdata", i), data_wdata, vecs[i].wdata);
            cyc();
            ex_valid_i = 0; data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hC0DE0000 + i;
            #1;
            chk($sformatf("v%0d_req1", i), data_req, 0);
            cyc();
            data_data_ok = 0;
            #1;
            chk($sformatf("v%0d_rvalid", i), mem_rvalid_o, 1);
            chk($sformatf("v%0d_rdata", i), mem_rdata_o, 32'hC0DE0000 + i);
            chk($sformatf("v%0d_alow", i), mem_addr_low_o, vecs[i].addr[1:0]);
        end

        // lb with addr_ok delayed three cycles: request fields held from the latch
        for (int c = 0; c < 4; c++) begin
            cyc();
            if (c == 0) issue(LB, 32'h103, 32'h0, 0);
            else ex_valid_i = 0;
            data_addr_ok = (c == 3);
            #1;
            chk($sformatf("lb_req%0d", c), data_req, 1);
            chk($sformatf("lb_addr%0d", c), data_addr, 32'h103);
            chk($sformatf("lb_size%0d", c), data_size, 0);
            chk($sformatf("lb_wr%0d", c), data_wr, 0);
            chk($sformatf("lb_stall%0d", c), stallreq_o, 1);
        end
        cyc();
        data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h80AA5511;
        #1;
        chk("lb_req4", data_req, 0);
        cyc();
        data_data_ok = 0;
        #1;
        chk("lb_rvalid", mem_rvalid_o, 1);
        chk("lb_rdata", mem_rdata_o, 32'h80AA5511);
        chk("lb_alow", mem_addr_low_o, 2'b11);

        // flush in WAIT, data_ok two cycles later goes to DISCARD
        cyc();
        issue(LW, 32'h300, 32'h0, 1);
        cyc();
        ex_valid_i = 0; data_addr_ok = 0; flush_i = 1;
        #1;
        chk("fl_stall1", stallreq_o, 1);
        cyc();
        flush_i = 0;
        #1;
        chk("fl_stall2", stallreq_o, 1);
        chk("fl_rvalid2", mem_rvalid_o, 0);
        cyc();
        data_data_ok = 1; data_rdata = 32'h12345678;
        #1;
        chk("fl_stall3", stallreq_o, 1);
        chk("fl_rvalid3", mem_rvalid_o, 0);
        cyc();
        data_data_ok = 0;
        #1;
        chk("fl_stall4", stallreq_o, 0);
        chk("fl_rvalid4", mem_rvalid_o, 0);
        chk("fl_rdata4", mem_rdata_o, 32'h80AA5511);

        // data_ok under pipe stall: held three cycles in HOLD
        cyc();
        issue(LW, 32'h304, 32'h0, 1);
        cyc();
        ex_valid_i = 0; data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hA5A5F00F; pipe_stall_i = 1;
        cyc();
        data_data_ok = 0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) cyc();
            if (c == 2) pipe_stall_i = 0;
            #1;
            chk($sformatf("hold_rvalid%0d", c), mem_rvalid_o, 1);
            chk($sformatf("hold_rdata%0d", c), mem_rdata_o, 32'hA5A5F00F);
            chk($sformatf("hold_stall%0d", c), stallreq_o, 0);
        end
        cyc();
        #1;
        chk("hold_rel", mem_rvalid_o, 0);

        // late data_ok in IDLE is ignored
        data_data_ok = 1; data_rdata = 32'hFFFFFFFF;
        cyc();
        data_data_ok = 0;
        #1;
        chk("late_rvalid", mem_rvalid_o, 0);
        chk("late_rdata", mem_rdata_o, 32'hA5A5F00F);

        // flush in REQ before addr_ok returns to IDLE
        cyc();
        issue(SB, 32'h400, 32'h55, 0);
        cyc();
        ex_valid_i = 0; flush_i = 1;
        #1;
        chk("frq_req1", data_req, 1);
        cyc();
        flush_i = 0;
        #1;
        chk("frq_req2", data_req, 0);
        chk("frq_stall2", stallreq_o, 0);

        // asynchronous reset while in REQ
        cyc();
        issue(SW, 32'h500, 32'h77, 0);
        cyc();
        #1;
        chk("ar_req_before", data_req, 1);
        rst_n = 1;
        #1;
        chk("ar_req", data_req, 0);
        chk("ar_wstrb", data_wstrb, 0);
        chk("ar_stall", stallreq_o, 0);
        chk("ar_rdata", mem_rdata_o, 0);
        chk("ar_rvalid", mem_rvalid_o, 0);
        ex_valid_i = 0;
        cyc();
        rst_n = 0;
        cyc();
        #1;
        chk("ar_idle_req", data_req, 0);
        chk("ar_idle_stall", stallreq_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
